state_variable_filter: RTL and testbench

//  Resonant 2-pole Chamberlin state-variable filter: LP/BP/HP (+opt. notch), one sample per sample_tick.

---
 rtl/svf_pkg.sv | 29 ++
 rtl/svf_sat.sv | 32 +++
 rtl/state_variable_filter.sv | 207 ++++++++++++++++++++
 tb/tb_state_variable_filter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svf_pkg.sv
// rtl/svf_pkg.sv - shared types and constants for the state-variable filter
// FSM state encoding, output mode codes, datapath widths and coefficient shifts.
package svf_pkg;

  localparam int DATA_W   = 16;
  localparam int IN_SHIFT = 6;
  localparam logic [7:0] F_MAX = 8'hC0;
  localparam int F_SHIFT  = 8;
  localparam int Q_SHIFT  = 7;

  localparam logic [2:0] MODE_BYP   = 3'b000;
  localparam logic [2:0] MODE_LP    = 3'b001;
  localparam logic [2:0] MODE_BP    = 3'b010;
  localparam logic [2:0] MODE_HP    = 3'b011;
  localparam logic [2:0] MODE_NOTCH = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    S_LOW,
    S_HIGH,
    S_BAND,
    S_OUT
  } svf_state_t;

  function automatic logic [7:0] clamp_coef(input logic [7:0] c, input logic [7:0] lim);
    return (c > lim) ? lim : c;
  endfunction

endpackage

// File: rtl/svf_sat.sv
// rtl/svf_sat.sv - saturating signed adder / clamp
// y = clamp(a + b); SYM=1 gives +/-(2^(OUT_W-1)-1), SYM=0 the full two's-complement range.
module svf_sat #(
  parameter int IN_W  = 27,
  parameter int OUT_W = 16,
  parameter bit SYM   = 1'b1
) (
  input  logic signed [IN_W-1:0]  i_a,
  input  logic signed [IN_W-1:0]  i_b,
  output logic signed [OUT_W-1:0] o_y
);

  localparam logic signed [IN_W:0] C_ONE = (IN_W+1)'(1);
  localparam logic signed [IN_W:0] C_MAX = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] C_MIN = SYM ? (-C_MAX) : (-C_MAX - C_ONE);

  logic signed [IN_W:0] w_sum;

  // One guard bit so the sum itself can never wrap before clamping
  assign w_sum = {i_a[IN_W-1], i_a} + {i_b[IN_W-1], i_b};

  always_comb begin
    if (w_sum > C_MAX) begin
      o_y = C_MAX[OUT_W-1:0];
    end else if (w_sum < C_MIN) begin
      o_y = C_MIN[OUT_W-1:0];
    end else begin
      o_y = w_sum[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/state_variable_filter.sv
// rtl/state_variable_filter.sv - resonant Chamberlin SVF, one shared multiplier, 5-state FSM
// Optional notch output on mode 100 when SVF_NOTCH_EN is defined.
module state_variable_filter #(
  parameter int         DATA_W   = svf_pkg::DATA_W,
  parameter int         IN_SHIFT = svf_pkg::IN_SHIFT,
  parameter logic [7:0] F_MAX    = svf_pkg::F_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_tick,
  input  logic [7:0] audio_in,
  input  logic [7:0] cutoff,
  input  logic [7:0] damping,
  input  logic [2:0] mode,
  output logic [7:0] audio_out,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun
);
  import svf_pkg::*;

  localparam int PW = DATA_W + 9;
  localparam int AW = DATA_W + 11;

  svf_state_t               r_state;
  logic signed [DATA_W-1:0] r_low;
  logic signed [DATA_W-1:0] r_band;
  logic signed [DATA_W-1:0] r_high;
  logic signed [DATA_W-1:0] r_in_s;
  logic [7:0]               r_f;
  logic [7:0]               r_q;
  logic [2:0]               r_mode;
  logic [7:0]               r_audio_out;
  logic                     r_out_valid;
  logic                     r_busy;
  logic                     r_overrun;

  logic [7:0]               w_in_x;
  logic signed [DATA_W-1:0] w_in_s;
  logic signed [DATA_W-1:0] w_mul_a;
  logic [7:0]               w_mul_coef;
  logic signed [PW-1:0]     w_mul_a_x;
  logic signed [PW-1:0]     w_mul_b_x;
  logic signed [PW-1:0]     w_prod;
  logic signed [AW-1:0]     w_prod_x;
  logic signed [AW-1:0]     w_prod_f;
  logic signed [AW-1:0]     w_prod_q;
  logic signed [AW-1:0]     w_acc_a;
  logic signed [AW-1:0]     w_acc_b;
  logic signed [DATA_W-1:0] w_state_sat;
  logic signed [DATA_W-1:0] w_sel;
  logic signed [DATA_W-1:0] w_sel_sh;
  logic signed [7:0]        w_out_s;

  function automatic logic signed [AW-1:0] ext(input logic signed [DATA_W-1:0] v);
    return {{(AW - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign w_in_x = audio_in ^ 8'h80;
  assign w_in_s = {{(DATA_W - 8 - IN_SHIFT){w_in_x[7]}}, w_in_x, {IN_SHIFT{1'b0}}};

  always_comb begin
    w_mul_a    = '0;
    w_mul_coef = '0;
    case (r_state)
      S_LOW:  begin w_mul_a = r_band; w_mul_coef = r_f; end
      S_HIGH: begin w_mul_a = r_band; w_mul_coef = r_q; end
      S_BAND: begin w_mul_a = r_high; w_mul_coef = r_f; end
      default: ;
    endcase
  end

  // Coefficients are unsigned, so they enter the signed multiply zero-extended
  assign w_mul_a_x = {{9{w_mul_a[DATA_W-1]}}, w_mul_a};
  assign w_mul_b_x = {{(PW - 8){1'b0}}, w_mul_coef};
  assign w_prod    = w_mul_a_x * w_mul_b_x;
  assign w_prod_x  = {{2{w_prod[PW-1]}}, w_prod};
  assign w_prod_f  = w_prod_x >>> F_SHIFT;
  assign w_prod_q  = w_prod_x >>> Q_SHIFT;

  always_comb begin
    w_acc_a = '0;
    w_acc_b = '0;
    case (r_state)
      S_LOW:  begin w_acc_a = ext(r_low);                w_acc_b = w_prod_f;  end
      S_HIGH: begin w_acc_a = ext(r_in_s) - ext(r_low);  w_acc_b = -w_prod_q; end
      S_BAND: begin w_acc_a = ext(r_band);               w_acc_b = w_prod_f;  end
      default: ;
    endcase
  end

  svf_sat #(.IN_W(AW), .OUT_W(DATA_W), .SYM(1'b1)) u_sat_state (
    .i_a (w_acc_a),
    .i_b (w_acc_b),
    .o_y (w_state_sat)
  );

`ifdef SVF_NOTCH_EN
  logic signed [DATA_W-1:0] w_notch;

  svf_sat #(.IN_W(DATA_W), .OUT_W(DATA_W), .SYM(1'b1)) u_sat_notch (
    .i_a (r_low),
    .i_b (r_high),
    .o_y (w_notch)
  );

  always_comb begin
    w_sel = r_in_s;
    case (r_mode)
      MODE_LP:    w_sel = r_low;
      MODE_BP:    w_sel = r_band;
      MODE_HP:    w_sel = r_high;
      MODE_NOTCH: w_sel = w_notch;
      default:    w_sel = r_in_s;
    endcase
  end
`else
  always_comb begin
    w_sel = r_in_s;
    casez (r_mode)
      3'b?01:  w_sel = r_low;
      3'b?10:  w_sel = r_band;
      3'b?11:  w_sel = r_high;
      default: w_sel = r_in_s;
    endcase
  end
`endif

  assign w_sel_sh = w_sel >>> IN_SHIFT;

  svf_sat #(.IN_W(DATA_W), .OUT_W(8), .SYM(1'b0)) u_sat_out (
    .i_a (w_sel_sh),
    .i_b ('0),
    .o_y (w_out_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_low       <= '0;
      r_band      <= '0;
      r_high      <= '0;
      r_in_s      <= '0;
      r_f         <= '0;
      r_q         <= '0;
      r_mode      <= '0;
      r_audio_out <= 8'h80;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (!enable) begin
      r_state     <= IDLE;
      r_low       <= '0;
      r_band      <= '0;
      r_high      <= '0;
      r_audio_out <= 8'h80;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (sample_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_in_s  <= w_in_s;
            r_f     <= clamp_coef(cutoff, F_MAX);
            r_q     <= damping;
            r_mode  <= mode;
            r_state <= S_LOW;
            r_busy  <= 1'b1;
          end
        end
        S_LOW: begin
          r_low   <= w_state_sat;
          r_state <= S_HIGH;
        end
        S_HIGH: begin
          r_high  <= w_state_sat;
          r_state <= S_BAND;
        end
        S_BAND: begin
          r_band  <= w_state_sat;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_audio_out <= w_out_s ^ 8'h80;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign audio_out = r_audio_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_state_variable_filter.sv
// tb/tb_state_variable_filter.sv - self-checking bench for state_variable_filter
// Vector table plus hand-written sequences; outputs checked through a scoreboard queue.
module tb_state_variable_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sample_tick;
  logic [7:0] audio_in;
  logic [7:0] cutoff;
  logic [7:0] damping;
  logic [2:0] mode;
  logic [7:0] audio_out;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  state_variable_filter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_tick (sample_tick),
    .audio_in    (audio_in),
    .cutoff      (cutoff),
    .damping     (damping),
    .mode        (mode),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in;
    logic [7:0] cut;
    logic [7:0] damp;
    logic [2:0] md;
    logic [7:0] exp;
  } vec_t;

  int         n_cmp   = 0;
  int         n_fail  = 0;
  int         n_valid = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         m_low, m_band, m_high;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d..%0d", name, act, act, lo, hi);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic logic [7:0] model_step(input logic [7:0] in, input logic [7:0] cut,
                                            input logic [7:0] damp, input logic [2:0] md);
    int ins, f, sel, o;
    ins = (int'(in) - 128) * 64;
    f = (cut > 8'hC0) ? 192 : int'(cut);
    m_low  = sat16(m_low + ((f * m_band) >>> 8));
    m_high = sat16(ins - m_low - ((int'(damp) * m_band) >>> 7));
    m_band = sat16(m_band + ((f * m_high) >>> 8));
`ifdef SVF_NOTCH_EN
    case (md)
      3'd1:    sel = m_low;
      3'd2:    sel = m_band;
      3'd3:    sel = m_high;
      3'd4:    sel = sat16(m_low + m_high);
      default: sel = ins;
    endcase
`else
    case (md[1:0])
      2'd1:    sel = m_low;
      2'd2:    sel = m_band;
      2'd3:    sel = m_high;
      default: sel = ins;
    endcase
`endif
    o = sel >>> 6;
    if (o > 127) o = 127;
    if (o < -128) o = -128;
    return 8'(o + 128);
  endfunction

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out_valid: actual audio_out 0x%02h required no pulse", audio_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard_audio_out", int'(audio_out), int'(mon_exp));
      end
    end
  end

  task automatic do_tick(input logic [7:0] in, input logic [7:0] cut, input logic [7:0] damp,
                         input logic [2:0] md, input logic [7:0] req);
    audio_in    = in;
    cutoff      = cut;
    damping     = damp;
    mode        = md;
    sample_tick = 1'b1;
    exp_q.push_back(req);
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("held_audio_out", int'(audio_out), int'(req));
  endtask

  task automatic model_tick(input logic [7:0] in, input logic [7:0] cut, input logic [7:0] damp,
                            input logic [2:0] md);
    logic [7:0] e;
    e = model_step(in, cut, damp, md);
    do_tick(in, cut, damp, md, e);
  endtask

  task automatic clear_states();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    m_low  = 0;
    m_band = 0;
    m_high = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    int   lat, busy_cnt, v0, jumps, prev, bmin, bmax;

    rst_n = 1'b0; enable = 1'b1; sample_tick = 1'b0;
    audio_in = 8'h80; cutoff = 8'h40; damping = 8'h80; mode = 3'b000;
    m_low = 0; m_band = 0; m_high = 0;
    repeat (3) @(negedge clk);
    check("reset_audio_out", int'(audio_out), 8'h80);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // first sample from cleared state: low=0, high=in_s, band=f*in_s/256
    vecs[0]  = '{8'h37, 8'h40, 8'h80, 3'b000, 8'h37};
    vecs[1]  = '{8'h00, 8'h40, 8'h80, 3'b000, 8'h00};
    vecs[2]  = '{8'hFF, 8'h40, 8'h80, 3'b000, 8'hFF};
    vecs[3]  = '{8'hC0, 8'h40, 8'h80, 3'b001, 8'h80};
    vecs[4]  = '{8'hC0, 8'h40, 8'h80, 3'b011, 8'hC0};
    vecs[5]  = '{8'hC0, 8'h40, 8'h80, 3'b010, 8'h90};
    vecs[6]  = '{8'hC0, 8'hFF, 8'h80, 3'b010, 8'hB0};
    vecs[7]  = '{8'h40, 8'h40, 8'h00, 3'b011, 8'h40};
    vecs[8]  = '{8'h00, 8'hC0, 8'h80, 3'b010, 8'h20};
`ifdef SVF_NOTCH_EN
    vecs[9]  = '{8'hC0, 8'h40, 8'h80, 3'b101, 8'hC0};
    vecs[10] = '{8'hC0, 8'h40, 8'h80, 3'b110, 8'hC0};
`else
    vecs[9]  = '{8'hC0, 8'h40, 8'h80, 3'b101, 8'h80};
    vecs[10] = '{8'hC0, 8'h40, 8'h80, 3'b110, 8'h90};
`endif
    for (int i = 0; i < 11; i++) begin
      clear_states();
      do_tick(vecs[i].in, vecs[i].cut, vecs[i].damp, vecs[i].md, vecs[i].exp);
    end

    // bypass latency and busy width
    clear_states();
    v0 = n_valid; lat = -1; busy_cnt = 0;
    audio_in = 8'h37; mode = 3'b000; sample_tick = 1'b1;
    exp_q.push_back(8'h37);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) sample_tick = 1'b0;
      if (busy) busy_cnt++;
      if (out_valid && lat < 0) lat = k - 1;
    end
    check("bypass_latency", lat, 4);
    check("bypass_busy_cycles", busy_cnt, 4);
    check("bypass_valid_pulses", n_valid - v0, 1);

    // DC convergence, then HP without clearing
    clear_states();
    repeat (400) model_tick(8'hC0, 8'h40, 8'h80, 3'b001);
    check_rng("lp_dc_converge", int'(audio_out), 8'hBF, 8'hC1);
    repeat (400) model_tick(8'hC0, 8'h40, 8'h80, 3'b011);
    check_rng("hp_dc_converge", int'(audio_out), 8'h7F, 8'h81);

    // max resonance, clamped cutoff, full-scale square input
    clear_states();
    jumps = 0; prev = int'(audio_out); bmin = 0; bmax = 0;
    for (int i = 0; i < 200; i++) begin
      model_tick(((i / 8) % 2) ? 8'hFF : 8'h00, 8'hFF, 8'h00, 3'b010);
      if ((prev == 8'hFF && audio_out == 8'h00) || (prev == 8'h00 && audio_out == 8'hFF)) jumps++;
      prev = int'(audio_out);
      if (int'($signed(dut.r_band)) < bmin) bmin = int'($signed(dut.r_band));
      if (int'($signed(dut.r_low)) < bmin) bmin = int'($signed(dut.r_low));
      if (int'($signed(dut.r_band)) > bmax) bmax = int'($signed(dut.r_band));
      if (int'($signed(dut.r_low)) > bmax) bmax = int'($signed(dut.r_low));
    end
    check("sat_no_wrap_jump", jumps, 0);
    check_rng("sat_state_min", bmin, -32767, 32767);
    check_rng("sat_state_max", bmax, -32767, 32767);

    // second tick two cycles into an update
    clear_states();
    v0 = n_valid;
    audio_in = 8'h37; mode = 3'b000; cutoff = 8'h40; damping = 8'h80; sample_tick = 1'b1;
    exp_q.push_back(model_step(8'h37, 8'h40, 8'h80, 3'b000));
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    audio_in = 8'h99; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (8) @(negedge clk);
    check("overrun_single_valid", n_valid - v0, 1);
    check("overrun_set", int'(overrun), 1);
    check("overrun_first_result", int'(audio_out), 8'h37);

    // enable dropped mid-update
    clear_states();
    model_tick(8'h37, 8'h40, 8'h80, 3'b000);
    v0 = n_valid;
    audio_in = 8'hC0; mode = 3'b001; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_audio_out", int'(audio_out), 8'h80);
    check("abort_low", int'($signed(dut.r_low)), 0);
    check("abort_band", int'($signed(dut.r_band)), 0);
    check("abort_high", int'($signed(dut.r_high)), 0);
    enable = 1'b1;
    m_low = 0; m_band = 0; m_high = 0;
    repeat (6) @(negedge clk);
    check("abort_no_valid", n_valid - v0, 0);
    check("overrun_sticky", int'(overrun), 1);

    // asynchronous reset while in S_HIGH
    model_tick(8'h37, 8'h40, 8'h80, 3'b000);
    audio_in = 8'hC0; mode = 3'b001; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_audio_out", int'(audio_out), 8'h80);
    check("midreset_busy", int'(busy), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_overrun", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_low = 0; m_band = 0; m_high = 0;
    v0 = n_valid;
    repeat (6) @(negedge clk);
    check("midreset_no_valid", n_valid - v0, 0);

    // mode 100: notch in the notch build, bypass otherwise; both settle at DC input
    clear_states();
    repeat (400) model_tick(8'hC0, 8'h40, 8'h80, 3'b100);
    check_rng("mode100_dc", int'(audio_out), 8'hBF, 8'hC1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
